// File: rtl/stage_mem.sv
// stage_mem: MEM stage of the 5-stage MIPS pipeline.
//   Captures EX results into the EX/MEM register. Performs word load/store
//   against an internal 2^AW-word data memory. Presents the MEM/WB register
//   to write-back.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   stall_in, flush_in     hazard-unit controls (flush wins in EX/MEM)
//   ans_ex, b_ex, rw_ex    EX result/address, store data, destination
//   wreg_ex, m2reg_ex,
//   wmem_ex                register-write / load / store controls
//   ans_mem, rw_mem,
//   wreg_mem, m2reg_mem    EX/MEM contents for forwarding and load-use checks
//   dout_wb, rw_wb,
//   wreg_wb                MEM/WB write-back value, destination, enable
//   align_err              sticky misaligned-access flag, cleared by rst
module stage_mem #(
  parameter int AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [31:0] ans_ex,
  input  logic [31:0] b_ex,
  input  logic [4:0]  rw_ex,
  input  logic        wreg_ex,
  input  logic        m2reg_ex,
  input  logic        wmem_ex,
  output logic [31:0] ans_mem,
  output logic [4:0]  rw_mem,
  output logic        wreg_mem,
  output logic        m2reg_mem,
  output logic [31:0] dout_wb,
  output logic [4:0]  rw_wb,
  output logic        wreg_wb,
  output logic        align_err
);

  logic [31:0] b_mem;
  logic        wmem_mem;

  logic [31:0] mem [0:(2**AW)-1];

  logic [AW-1:0] word_addr;
  logic [31:0]   rdata;
  logic          misaligned;
  logic          misaligned_load;
  logic          do_write;

  // Bits above AW+1 are dropped, so addresses wrap modulo 2^AW words.
  assign word_addr       = ans_mem[AW+1:2];
  assign rdata           = mem[word_addr];
  assign misaligned      = (m2reg_mem | wmem_mem) & (ans_mem[1:0] != 2'b00);
  assign misaligned_load = m2reg_mem & (ans_mem[1:0] != 2'b00);
  // A stalled store keeps its slot in EX/MEM and commits only on its last cycle.
  assign do_write        = wmem_mem & ~stall_in & ~rst & (ans_mem[1:0] == 2'b00);

  // EX/MEM register
  always_ff @(posedge clk) begin
    if (rst) begin
      ans_mem   <= '0;
      b_mem     <= '0;
      rw_mem    <= '0;
      wreg_mem  <= 1'b0;
      m2reg_mem <= 1'b0;
      wmem_mem  <= 1'b0;
    end else if (flush_in) begin
      // Bubble: only the controls are cleared; data fields are left as-is.
      wreg_mem  <= 1'b0;
      m2reg_mem <= 1'b0;
      wmem_mem  <= 1'b0;
    end else if (!stall_in) begin
      ans_mem   <= ans_ex;
      b_mem     <= b_ex;
      rw_mem    <= rw_ex;
      wreg_mem  <= wreg_ex & (rw_ex != 5'd0);
      m2reg_mem <= m2reg_ex;
      wmem_mem  <= wmem_ex;
    end
  end

  // Data memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[word_addr] <= b_mem;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk) begin
    if (rst || stall_in) begin
      dout_wb <= '0;
      rw_wb   <= '0;
      wreg_wb <= 1'b0;
    end else begin
      if (m2reg_mem) begin
        dout_wb <= misaligned_load ? 32'd0 : rdata;
      end else begin
        dout_wb <= ans_mem;
      end
      rw_wb   <= rw_mem;
      wreg_wb <= wreg_mem & ~misaligned_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      align_err <= 1'b0;
    end else if (misaligned) begin
      align_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
module tb_stage_mem;

  logic        clk;
  logic        rst;
  logic        stall_in;
  logic        flush_in;
  logic [31:0] ans_ex;
  logic [31:0] b_ex;
  logic [4:0]  rw_ex;
  logic        wreg_ex;
  logic        m2reg_ex;
  logic        wmem_ex;
  logic [31:0] ans_mem;
  logic [4:0]  rw_mem;
  logic        wreg_mem;
  logic        m2reg_mem;
  logic [31:0] dout_wb;
  logic [4:0]  rw_wb;
  logic        wreg_wb;
  logic        align_err;

  int checks = 0;
  int errors = 0;

  stage_mem #(.AW(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall_in  (stall_in),
    .flush_in  (flush_in),
    .ans_ex    (ans_ex),
    .b_ex      (b_ex),
    .rw_ex     (rw_ex),
    .wreg_ex   (wreg_ex),
    .m2reg_ex  (m2reg_ex),
    .wmem_ex   (wmem_ex),
    .ans_mem   (ans_mem),
    .rw_mem    (rw_mem),
    .wreg_mem  (wreg_mem),
    .m2reg_mem (m2reg_mem),
    .dout_wb   (dout_wb),
    .rw_wb     (rw_wb),
    .wreg_wb   (wreg_wb),
    .align_err (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rw,
                        input logic wr, input logic ld, input logic st);
    ans_ex   = a;
    b_ex     = b;
    rw_ex    = rw;
    wreg_ex  = wr;
    m2reg_ex = ld;
    wmem_ex  = st;
  endtask

  task automatic nop();
    set_ex(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    stall_in = 1'b0;
    flush_in = 1'b0;
    set_ex(32'd0, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0);

    // Reset held two cycles with a live instruction on the EX inputs
    tick();
    tick();
    check("rst_ans_mem",   ans_mem,   32'd0);
    check("rst_rw_mem",    rw_mem,    32'd0);
    check("rst_wreg_mem",  wreg_mem,  32'd0);
    check("rst_m2reg_mem", m2reg_mem, 32'd0);
    check("rst_dout_wb",   dout_wb,   32'd0);
    check("rst_rw_wb",     rw_wb,     32'd0);
    check("rst_wreg_wb",   wreg_wb,   32'd0);
    check("rst_align_err", align_err, 32'd0);

    rst = 1'b0;
    tick();
    check("post_rst_wreg_mem", wreg_mem, 32'd1);
    check("post_rst_rw_mem",   rw_mem,   32'd5);
    check("post_rst_wreg_wb",  wreg_wb,  32'd0);

    // ALU pass-through, then rw=0 variant
    set_ex(32'h1234, 32'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    check("alu_ans_mem", ans_mem, 32'h1234);
    set_ex(32'h5678, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check("alu_dout_wb",     dout_wb,  32'h1234);
    check("alu_rw_wb",       rw_wb,    32'd8);
    check("alu_wreg_wb",     wreg_wb,  32'd1);
    check("rw0_wreg_mem",    wreg_mem, 32'd0);
    nop();
    tick();
    check("rw0_dout_wb", dout_wb, 32'h5678);
    check("rw0_wreg_wb", wreg_wb, 32'd0);

    // Store then immediate load of the same word; then wrapped address
    set_ex(32'h40, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    set_ex(32'h40, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    check("lw_m2reg_mem", m2reg_mem, 32'd1);
    set_ex(32'h1040, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    check("lw_dout_wb", dout_wb, 32'hDEADBEEF);
    check("lw_rw_wb",   rw_wb,   32'd3);
    check("lw_wreg_wb", wreg_wb, 32'd1);
    nop();
    tick();
    check("wrap_dout_wb", dout_wb, 32'hDEADBEEF);
    check("wrap_rw_wb",   rw_wb,   32'd4);

    // Stalled store: pre-write 0x11, then hold sw 0x5 for three cycles
    set_ex(32'h80, 32'h11, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    set_ex(32'h80, 32'h5, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check("pre_store_mem", dut.mem[32], 32'h11);
    stall_in = 1'b1;
    set_ex(32'h999, 32'h77, 5'd7, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ans_mem", ans_mem,     32'h80);
      check("stall_wreg_wb", wreg_wb,     32'd0);
      check("stall_mem_old", dut.mem[32], 32'h11);
    end
    stall_in = 1'b0;
    set_ex(32'h80, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    check("unstall_mem_new", dut.mem[32], 32'h5);
    nop();
    tick();
    check("stall_lw_dout_wb", dout_wb, 32'h5);
    check("stall_lw_wreg_wb", wreg_wb, 32'd1);
    check("stall_lw_rw_wb",   rw_wb,   32'd9);

    // Flush together with stall while a load sits in EX
    set_ex(32'h40, 32'd0, 5'd6, 1'b1, 1'b1, 1'b0);
    flush_in = 1'b1;
    stall_in = 1'b1;
    tick();
    check("flush_wreg_mem",  wreg_mem,  32'd0);
    check("flush_m2reg_mem", m2reg_mem, 32'd0);
    check("flush_wreg_wb",   wreg_wb,   32'd0);
    flush_in = 1'b0;
    stall_in = 1'b0;
    nop();
    tick();
    check("flush_wb_bubble", wreg_wb, 32'd0);
    tick();
    check("flush_wb_bubble2", wreg_wb, 32'd0);

    // Misaligned store and load
    check("align_err_clear", align_err, 32'd0);
    set_ex(32'h42, 32'h12345678, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    nop();
    tick();
    check("mis_sw_align_err", align_err,   32'd1);
    check("mis_sw_mem_kept",  dut.mem[16], 32'hDEADBEEF);
    set_ex(32'h43, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    check("mis_lw_wreg_wb", wreg_wb, 32'd0);
    check("mis_lw_dout_wb", dout_wb, 32'd0);
    set_ex(32'h40, 32'd0, 5'd11, 1'b1, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    check("mis_after_dout_wb", dout_wb,   32'hDEADBEEF);
    check("mis_after_wreg_wb", wreg_wb,   32'd1);
    check("align_err_sticky",  align_err, 32'd1);

    // Reset clears align_err; reset in the store's MEM cycle blocks the write
    rst = 1'b1;
    tick();
    check("rst2_align_err", align_err, 32'd0);
    rst = 1'b0;
    set_ex(32'h40, 32'hAA, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    rst = 1'b1;
    nop();
    tick();
    rst = 1'b0;
    set_ex(32'h40, 32'd0, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    check("rst_store_dout_wb", dout_wb, 32'hDEADBEEF);
    check("rst_store_rw_wb",   rw_wb,   32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
